// File: rtl/uart_fifo_core_if.sv
// Peripheral-bus side of the UART: register address/strobes, write data,
// registered read data and the level interrupt.
interface uart_fifo_core_if;
    logic [31:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        interrupt;

    modport master (
        output addr, wren, rden, din,
        input  dout, dout_valid, interrupt
    );

    modport slave (
        input  addr, wren, rden, din,
        output dout, dout_valid, interrupt
    );
endinterface

// File: rtl/uart_fifo_core.sv
// Buffered UART peripheral: programmable 16x baud tick, TX/RX FIFOs, parity,
// one or two stop bits, CTS hold, sticky W1C error flags and a level interrupt.
module uart_fifo_core_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status is taken from the registered count, so a push into a full FIFO is
    // refused and a pop from an empty one ignored even if the other side moves.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

module uart_fifo_core #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd53
) (
    input  logic            clk,
    input  logic            rst,
    uart_fifo_core_if.slave bus,
    output logic            uart_tx,
    input  logic            uart_rx,
    input  logic            uart_cts
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic [15:0] div_q;
    logic [1:0]  parity_q;
    logic        two_stop_q;
    logic        rx_ie_q;
    logic        tx_ie_q;
    logic        err_ie_q;
    logic [3:0]  err_q;
    logic [3:0]  err_set;

    logic [1:0]  reg_sel;
    logic        wr_data;
    logic        wr_ctrl;
    logic        wr_err;
    logic        rd_data;
    logic [31:0] dout_q;
    logic        dout_valid_q;

    logic [15:0] baud_cnt;
    logic        tick;

    logic        tx_full;
    logic        tx_empty;
    logic [AW:0] tx_count;
    logic [7:0]  tx_fifo_dout;
    logic        rx_full;
    logic        rx_empty;
    logic [AW:0] rx_count;
    logic [7:0]  rx_fifo_dout;

    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic        tx_pop;
    logic        tx_bit_end;
    logic [3:0]  tx_tick_cnt;
    logic [2:0]  tx_bit_cnt;
    logic [7:0]  tx_shift;
    logic        tx_par_en;
    logic        tx_par_bit;
    logic        tx_two_stop;
    logic        tx_line;
    logic        tx_busy;

    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic        rx_push;
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic [3:0]  rx_tick_cnt;
    logic [2:0]  rx_bit_cnt;
    logic [7:0]  rx_shift;
    logic        rx_par_en;
    logic        rx_par_odd;
    logic        rx_par_bit;

    logic        unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din[31:22]};

    assign reg_sel = bus.addr[3:2];
    assign wr_data = bus.wren && (reg_sel == 2'd0);
    assign wr_ctrl = bus.wren && (reg_sel == 2'd2);
    assign wr_err  = bus.wren && (reg_sel == 2'd3);
    assign rd_data = bus.rden && (reg_sel == 2'd0);

    function automatic logic [7:0] sat8(input logic [AW:0] c);
        logic [8:0] c9;
        c9 = 9'(c);
        return c9[8] ? 8'hFF : c9[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_RESET;
            parity_q   <= 2'b00;
            two_stop_q <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            err_ie_q   <= 1'b0;
        end else if (wr_ctrl) begin
            div_q      <= bus.din[15:0];
            parity_q   <= bus.din[17:16];
            two_stop_q <= bus.din[18];
            rx_ie_q    <= bus.din[19];
            tx_ie_q    <= bus.din[20];
            err_ie_q   <= bus.din[21];
        end
    end

    // A CTRL write restarts the tick so a new divisor starts from a clean phase.
    assign tick = (baud_cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst || wr_ctrl || tick) baud_cnt <= '0;
        else                        baud_cnt <= baud_cnt + 16'd1;
    end

    uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .din   (bus.din[7:0]),
        .pop   (tx_pop),
        .dout  (tx_fifo_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rd_data),
        .dout  (rx_fifo_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);
    assign tx_busy    = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // Frames only start on a tick so every bit spans exactly 16 ticks; the end
    // of the last stop bit may chain straight into the next queued byte.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty && !uart_cts) begin
                    tx_next = TX_START;
                    tx_pop  = 1'b1;
                end
            end
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end && tx_bit_cnt == 3'd7)
                    tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end && (!tx_two_stop || tx_bit_cnt == 3'd1)) begin
                    if (!tx_empty && !uart_cts) begin
                        tx_next = TX_START;
                        tx_pop  = 1'b1;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_two_stop <= 1'b0;
        end else if (tx_pop) begin
            tx_shift    <= tx_fifo_dout;
            tx_par_en   <= (parity_q == 2'b01) || (parity_q == 2'b10);
            tx_par_bit  <= (^tx_fifo_dout) ^ (parity_q == 2'b10);
            tx_two_stop <= two_stop_q;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tick && tx_state != TX_IDLE) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
                if (tx_state == TX_DATA) begin
                    tx_shift   <= {1'b0, tx_shift[7:1]};
                    tx_bit_cnt <= tx_bit_cnt + 3'd1;
                end else if (tx_state == TX_STOP) begin
                    tx_bit_cnt <= tx_bit_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par_bit;
            default:   tx_line = 1'b1;
        endcase
    end

    // Registered so the serial line never glitches while the FSM changes state.
    always_ff @(posedge clk) begin
        if (rst) uart_tx <= 1'b1;
        else     uart_tx <= tx_line;
    end

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE:  if (tick && !rx_s) rx_next = RX_START;
            RX_START: if (tick && rx_tick_cnt == 4'd7) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && rx_tick_cnt == 4'd15 && rx_bit_cnt == 3'd7)
                    rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (tick && rx_tick_cnt == 4'd15) rx_next = RX_STOP;
            RX_STOP: begin
                if (tick && rx_tick_cnt == 4'd15) begin
                    rx_next = RX_IDLE;
                    rx_push = 1'b1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync     <= 2'b11;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_par_en   <= 1'b0;
            rx_par_odd  <= 1'b0;
            rx_par_bit  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            if (rx_state == RX_IDLE) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
                if (rx_next == RX_START) begin
                    rx_par_en  <= (parity_q == 2'b01) || (parity_q == 2'b10);
                    rx_par_odd <= (parity_q == 2'b10);
                end
            end else if (tick) begin
                if (rx_state == RX_START && rx_tick_cnt == 4'd7) rx_tick_cnt <= '0;
                else                                             rx_tick_cnt <= rx_tick_cnt + 4'd1;
                if (rx_tick_cnt == 4'd15) begin
                    case (rx_state)
                        RX_DATA: begin
                            rx_shift   <= {rx_s, rx_shift[7:1]};
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        end
                        RX_PARITY: rx_par_bit <= rx_s;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        err_set    = 4'b0000;
        err_set[0] = wr_data && tx_full;
        err_set[1] = rx_push && rx_full;
        err_set[2] = rx_push && !rx_s;
        err_set[3] = rx_push && rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd));
    end

    // New error events win over a simultaneous W1C clear.
    always_ff @(posedge clk) begin
        if (rst)         err_q <= 4'b0000;
        else if (wr_err) err_q <= (err_q & ~bus.din[3:0]) | err_set;
        else             err_q <= err_q | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= bus.rden;
            if (bus.rden) begin
                case (reg_sel)
                    2'd0: dout_q <= rx_empty ? 32'd0 : {23'd0, 1'b1, rx_fifo_dout};
                    2'd1: dout_q <= {8'd0, sat8(tx_count), sat8(rx_count), 3'd0,
                                     tx_busy, tx_full, tx_empty, rx_full, rx_empty};
                    2'd2: dout_q <= {10'd0, err_ie_q, tx_ie_q, rx_ie_q, two_stop_q,
                                     parity_q, div_q};
                    default: dout_q <= {28'd0, err_q};
                endcase
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.interrupt  = (rx_ie_q && !rx_empty) ||
                            (tx_ie_q && tx_empty && !tx_busy) ||
                            (err_ie_q && (err_q != 4'b0000));
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: register access, TX framing, loopback,
// CTS hold, RX overrun, error flags and mid-frame reset.
module tb_uart_fifo_core;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [15:0] DIV_RESET  = 16'd53;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic uart_rx;
    logic uart_cts = 1'b0;
    logic rx_drive = 1'b1;
    logic loop_en  = 1'b0;

    int checks = 0;
    int passes = 0;

    uart_fifo_core_if bus ();

    assign uart_rx = loop_en ? uart_tx : rx_drive;

    uart_fifo_core #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx),
        .uart_cts (uart_cts)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.din  = d;
        bus.wren = 1'b1;
        @(negedge clk);
        bus.wren = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        bus.addr = a;
        bus.rden = 1'b1;
        @(negedge clk);
        bus.rden = 1'b0;
        d = bus.dout;
        v = bus.dout_valid;
    endtask

    // Waits (bounded) for a start bit, then samples each bit at mid-bit (DIV=0).
    task automatic tx_capture(input int nbits, input bit raise_cts,
                              output logic [15:0] bits, output int waited);
        waited = 0;
        bits   = 16'hFFFF;
        while (uart_tx !== 1'b0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (uart_tx !== 1'b0) begin
            waited = -1;
        end else begin
            if (raise_cts) uart_cts = 1'b1;
            repeat (8) @(negedge clk);
            bits[0] = uart_tx;
            for (int i = 1; i < nbits; i++) begin
                repeat (16) @(negedge clk);
                bits[i] = uart_tx;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int par_mode,
                              input bit flip_par, input logic stop_val);
        logic p;
        @(negedge clk);
        rx_drive = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[i];
            repeat (16) @(negedge clk);
        end
        if (par_mode != 0) begin
            p = (^b) ^ (par_mode == 2);
            if (flip_par) p = ~p;
            rx_drive = p;
            repeat (16) @(negedge clk);
        end
        rx_drive = stop_val;
        repeat (16) @(negedge clk);
        rx_drive = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) $display("[TB] FAIL reset_tx got=%b exp=1", uart_tx); else passes++;
        checks++; if (bus.interrupt !== 1'b0) $display("[TB] FAIL reset_irq got=%b exp=0", bus.interrupt); else passes++;
        checks++; if (bus.dout_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", bus.dout_valid); else passes++;
        checks++; if (bus.dout !== 32'd0) $display("[TB] FAIL reset_dout got=%h exp=0", bus.dout); else passes++;
        rst = 1'b0;
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h5) $display("[TB] FAIL reset_status got=%h exp=%h", d, 32'h5); else passes++;
        checks++; if (v !== 1'b1) $display("[TB] FAIL read_valid got=%b exp=1", v); else passes++;
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0) $display("[TB] FAIL valid_pulse got=%b exp=0", bus.dout_valid); else passes++;
        checks++; if (bus.dout !== 32'h5) $display("[TB] FAIL dout_hold got=%h exp=%h", bus.dout, 32'h5); else passes++;
        bus_read(32'h8, d, v);
        checks++; if (d !== 32'd53) $display("[TB] FAIL reset_ctrl got=%h exp=%h", d, 32'd53); else passes++;
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'd0) $display("[TB] FAIL reset_err got=%h exp=0", d); else passes++;
        bus_read(32'h0, d, v);
        checks++; if (d !== 32'd0) $display("[TB] FAIL empty_data got=%h exp=0", d); else passes++;
    endtask

    task automatic test_tx_frame();
        logic [31:0] d;
        logic        v;
        logic [8:0]  frame;
        int          waited;
        int          len;
        bus_write(32'h8, 32'h0);
        bus_write(32'h0, 32'h55);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (uart_tx !== 1'b0 || waited > 3) $display("[TB] FAIL tx_latency got=%0d exp<=3", waited); else passes++;
        len = 0;
        while (uart_tx === 1'b0 && len < 100) begin
            @(negedge clk);
            len++;
        end
        checks++; if (len != 16) $display("[TB] FAIL start_bit_len got=%0d exp=16", len); else passes++;
        repeat (8) @(negedge clk);
        frame[0] = uart_tx;
        for (int i = 1; i < 9; i++) begin
            repeat (16) @(negedge clk);
            frame[i] = uart_tx;
        end
        checks++; if (frame !== 9'h155) $display("[TB] FAIL tx_frame_55 got=%h exp=%h", frame, 9'h155); else passes++;
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h15) $display("[TB] FAIL status_busy got=%h exp=%h", d, 32'h15); else passes++;
        repeat (8) @(negedge clk);
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h5) $display("[TB] FAIL status_idle got=%h exp=%h", d, 32'h5); else passes++;
        bus_write(32'h8, 32'h0010_0000);
        checks++; if (bus.interrupt !== 1'b1) $display("[TB] FAIL tx_irq got=%b exp=1", bus.interrupt); else passes++;
        bus_write(32'h8, 32'h0);
        checks++; if (bus.interrupt !== 1'b0) $display("[TB] FAIL tx_irq_off got=%b exp=0", bus.interrupt); else passes++;
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_rd [4];
        bit          got;
        exp_rd[0] = 32'h1A7;
        exp_rd[1] = 32'h100;
        exp_rd[2] = 32'h1FF;
        exp_rd[3] = 32'h000;
        loop_en = 1'b1;
        bus_write(32'h8, 32'h0005_0000);
        bus_write(32'h0, 32'hA7);
        bus_write(32'h0, 32'h00);
        bus_write(32'h0, 32'hFF);
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            bus_read(32'h4, d, v);
            if (d[15:8] == 8'd3) begin
                got = 1'b1;
                break;
            end
            repeat (30) @(negedge clk);
        end
        checks++; if (!got) $display("[TB] FAIL loop_rx_count got=%0d exp=3", d[15:8]); else passes++;
        for (int i = 0; i < 4; i++) begin
            bus_read(32'h0, d, v);
            checks++; if (d !== exp_rd[i]) $display("[TB] FAIL loop_read%0d got=%h exp=%h", i, d, exp_rd[i]); else passes++;
        end
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'd0) $display("[TB] FAIL loop_err got=%h exp=0", d); else passes++;
        repeat (200) @(negedge clk);
        loop_en = 1'b0;
        bus_write(32'h8, 32'h0);
    endtask

    task automatic test_cts();
        logic [31:0] d;
        logic        v;
        logic [15:0] bits;
        int          waited;
        int          lows;
        uart_cts = 1'b1;
        bus_write(32'h0, 32'h11);
        bus_write(32'h0, 32'h22);
        bus_write(32'h0, 32'h33);
        bus_write(32'h0, 32'h44);
        lows = 0;
        repeat (64) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) $display("[TB] FAIL cts_hold got=%0d exp=0", lows); else passes++;
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h0004_0001) $display("[TB] FAIL cts_status got=%h exp=%h", d, 32'h0004_0001); else passes++;
        uart_cts = 1'b0;
        tx_capture(10, 1'b0, bits, waited);
        checks++; if (bits[9:0] !== 10'h222) $display("[TB] FAIL cts_frame11 got=%h exp=%h", bits[9:0], 10'h222); else passes++;
        tx_capture(10, 1'b0, bits, waited);
        checks++; if (bits[9:0] !== 10'h244) $display("[TB] FAIL cts_frame22 got=%h exp=%h", bits[9:0], 10'h244); else passes++;
        checks++; if (waited < 0 || waited > 8) $display("[TB] FAIL back_to_back got=%0d exp<=8", waited); else passes++;
        tx_capture(10, 1'b1, bits, waited);
        checks++; if (bits[9:0] !== 10'h266) $display("[TB] FAIL cts_frame33 got=%h exp=%h", bits[9:0], 10'h266); else passes++;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) $display("[TB] FAIL cts_midframe_hold got=%0d exp=0", lows); else passes++;
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h0001_0001) $display("[TB] FAIL cts_status2 got=%h exp=%h", d, 32'h0001_0001); else passes++;
        uart_cts = 1'b0;
        tx_capture(10, 1'b0, bits, waited);
        checks++; if (bits[9:0] !== 10'h288) $display("[TB] FAIL cts_frame44 got=%h exp=%h", bits[9:0], 10'h288); else passes++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic        v;
        logic [7:0]  exp_b [FIFO_DEPTH+1];
        for (int i = 0; i <= FIFO_DEPTH; i++) exp_b[i] = 8'((i * 37 + 5) & 8'hFF);
        for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(exp_b[i], 0, 1'b0, 1'b1);
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h0000_1006) $display("[TB] FAIL rx_full_status got=%h exp=%h", d, 32'h0000_1006); else passes++;
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'h2) $display("[TB] FAIL rx_overrun got=%h exp=%h", d, 32'h2); else passes++;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus_read(32'h0, d, v);
            checks++; if (d !== {23'd0, 1'b1, exp_b[i]}) $display("[TB] FAIL rx_order%0d got=%h exp=%h", i, d, {23'd0, 1'b1, exp_b[i]}); else passes++;
        end
        bus_write(32'hC, 32'h2);
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'h0) $display("[TB] FAIL overrun_clear got=%h exp=0", d); else passes++;
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        v;
        bus_write(32'h8, 32'h0022_0000);
        send_frame(8'h5A, 2, 1'b1, 1'b1);
        send_frame(8'h3C, 2, 1'b0, 1'b0);
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'hC) $display("[TB] FAIL err_flags got=%h exp=%h", d, 32'hC); else passes++;
        checks++; if (bus.interrupt !== 1'b1) $display("[TB] FAIL err_irq got=%b exp=1", bus.interrupt); else passes++;
        bus_read(32'h0, d, v);
        checks++; if (d !== 32'h15A) $display("[TB] FAIL err_byte0 got=%h exp=%h", d, 32'h15A); else passes++;
        bus_read(32'h0, d, v);
        checks++; if (d !== 32'h13C) $display("[TB] FAIL err_byte1 got=%h exp=%h", d, 32'h13C); else passes++;
        bus_write(32'hC, 32'hC);
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'h0) $display("[TB] FAIL err_w1c got=%h exp=0", d); else passes++;
        checks++; if (bus.interrupt !== 1'b0) $display("[TB] FAIL err_irq_off got=%b exp=0", bus.interrupt); else passes++;
        bus_write(32'h8, 32'h0);
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic        v;
        uart_cts = 1'b1;
        for (int i = 0; i <= FIFO_DEPTH; i++) bus_write(32'h0, 32'(i));
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h0010_0009) $display("[TB] FAIL tx_full_status got=%h exp=%h", d, 32'h0010_0009); else passes++;
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'h1) $display("[TB] FAIL tx_overflow got=%h exp=%h", d, 32'h1); else passes++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic        v;
        int          waited;
        uart_cts = 1'b0;
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (40) @(negedge clk);
        checks++; if (uart_tx !== 1'b0) $display("[TB] FAIL midframe_low got=%b exp=0", uart_tx); else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) $display("[TB] FAIL reset_abort_tx got=%b exp=1", uart_tx); else passes++;
        rst = 1'b0;
        bus_read(32'h4, d, v);
        checks++; if (d !== 32'h5) $display("[TB] FAIL reset2_status got=%h exp=%h", d, 32'h5); else passes++;
        bus_read(32'h8, d, v);
        checks++; if (d !== 32'd53) $display("[TB] FAIL reset2_ctrl got=%h exp=%h", d, 32'd53); else passes++;
        bus_read(32'hC, d, v);
        checks++; if (d !== 32'h0) $display("[TB] FAIL reset2_err got=%h exp=0", d); else passes++;
    endtask

    initial begin
        bus.addr = '0;
        bus.din  = '0;
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        test_reset();
        test_tx_frame();
        test_loopback();
        test_cts();
        test_rx_overrun();
        test_errors();
        test_tx_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
